writeback_regfile: RTL and testbench

- Writeback stage plus architectural register file, sitting directly downstream of the MEM/WB pipeline register.
- Selects the writeback value from the MEM/WB outputs and commits it to a 32-entry register file.
- Serves the two decode-stage read ports with a same-cycle write-to-read bypass.
- Exports the writeback value for EX forwarding and a 64-bit retired-writeback counter.

---
 rtl/writeback_regfile_pkg.sv | 15 +
 rtl/writeback_regfile_rf.sv | 55 +++++
 rtl/writeback_regfile.sv | 78 +++++++
 tb/tb_writeback_regfile.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared types and constants for the writeback stage and its register file.
package writeback_regfile_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_PC4   = 3'd2,
    WB_IMM   = 3'd3,
    WB_PCIMM = 3'd4
  } wb_src_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PC_INCR    = 4;

endpackage

// File: rtl/writeback_regfile_rf.sv
// 32-entry, two-read/one-write register file with hardwired x0,
// synchronous clear and same-cycle write-to-read bypass.
module regfile_2r1w
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en && (wr_addr != '0) && !rst;

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Bypass takes priority over the array so a same-cycle write is never read stale.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (!rst) begin
      if (rd_addr1 == '0)                       rd_data1 = '0;
      else if (wr_ok && (rd_addr1 == wr_addr))  rd_data1 = wr_data;
      else                                      rd_data1 = regs_q[rd_addr1];
      if (rd_addr2 == '0)                       rd_data2 = '0;
      else if (wr_ok && (rd_addr2 == wr_addr))  rd_data2 = wr_data;
      else                                      rd_data2 = regs_q[rd_addr2];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: source select from MEM/WB, register file commit,
// forwarding export and a 64-bit retired-writeback counter.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MemRdData,
  input  logic [DATA_W-1:0]     MemALUresult,
  input  logic [DM_ADDRESS-1:0] PC,
  input  logic [DATA_W-1:0]     imm,
  input  logic                  RegWrtEn,
  input  logic [2:0]            RegWrtSrc,
  input  logic [4:0]            RegDst,
  input  logic [4:0]            RdAddr1,
  input  logic [4:0]            RdAddr2,
  output logic [DATA_W-1:0]     RdData1,
  output logic [DATA_W-1:0]     RdData2,
  output logic [DATA_W-1:0]     WbData,
  output logic                  WbValid,
  output logic [63:0]           RetireCnt
);

  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] wb_data;
  logic [63:0]       retire_cnt_q;
  logic [63:0]       retire_cnt_d;

  assign pc_ext = DATA_W'(PC);

  always_comb begin
    wb_data = '0;
    case (wb_src_e'(RegWrtSrc))
      WB_ALU:   wb_data = MemALUresult;
      WB_MEM:   wb_data = MemRdData;
      WB_PC4:   wb_data = pc_ext + DATA_W'(PC_INCR);
      WB_IMM:   wb_data = imm;
      WB_PCIMM: wb_data = pc_ext + imm;
      default:  wb_data = '0;
    endcase
  end

  assign WbData  = wb_data;
  assign WbValid = RegWrtEn && (RegDst != '0) && !rst;

  // Counts every retired writeback, x0 destinations included.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (rst)           retire_cnt_d = '0;
    else if (RegWrtEn) retire_cnt_d = retire_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    retire_cnt_q <= retire_cnt_d;
  end

  assign RetireCnt = retire_cnt_q;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (RegWrtEn),
    .wr_addr  (RegDst),
    .wr_data  (wb_data),
    .rd_addr1 (RdAddr1),
    .rd_addr2 (RdAddr2),
    .rd_data1 (RdData1),
    .rd_data2 (RdData2)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with hand-computed expectations.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] MemRdData;
  logic [31:0] MemALUresult;
  logic [8:0]  PC;
  logic [31:0] imm;
  logic        RegWrtEn;
  logic [2:0]  RegWrtSrc;
  logic [4:0]  RegDst;
  logic [4:0]  RdAddr1;
  logic [4:0]  RdAddr2;
  logic [31:0] RdData1;
  logic [31:0] RdData2;
  logic [31:0] WbData;
  logic        WbValid;
  logic [63:0] RetireCnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  writeback_regfile #(
    .DM_ADDRESS (9),
    .DATA_W     (32),
    .NUM_REGS   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRdData    (MemRdData),
    .MemALUresult (MemALUresult),
    .PC           (PC),
    .imm          (imm),
    .RegWrtEn     (RegWrtEn),
    .RegWrtSrc    (RegWrtSrc),
    .RegDst       (RegDst),
    .RdAddr1      (RdAddr1),
    .RdAddr2      (RdAddr2),
    .RdData1      (RdData1),
    .RdData2      (RdData2),
    .WbData       (WbData),
    .WbValid      (WbValid),
    .RetireCnt    (RetireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a write to x7, check bypass this cycle and array next cycle.
  task automatic wr_x7(input string tag, input logic [2:0] src, input logic [8:0] pc,
                       input logic [31:0] im, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] exp);
    RegWrtEn = 1'b1; RegWrtSrc = src; RegDst = 5'd7; RdAddr2 = 5'd7;
    PC = pc; imm = im; MemALUresult = alu; MemRdData = mem;
    #1;
    chk({tag, "_wbdata"}, 64'(WbData), 64'(exp));
    chk({tag, "_bypass"}, 64'(RdData2), 64'(exp));
    tick();
    RegWrtEn = 1'b0;
    #1;
    chk({tag, "_array"}, 64'(RdData2), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; RegWrtEn = 1'b1; RegWrtSrc = 3'd0; RegDst = 5'd3;
    MemALUresult = 32'h0000_1234; MemRdData = '0; PC = '0; imm = '0;
    RdAddr1 = 5'd3; RdAddr2 = 5'd3;
    tick();
    tick();
    // Outputs while in reset
    chk("rst_rd1",     64'(RdData1), 64'd0);
    chk("rst_wbvalid", 64'(WbValid), 64'd0);
    chk("rst_wbdata",  64'(WbData),  64'h1234);
    chk("rst_cnt",     RetireCnt,    64'd0);

    rst = 1'b0; RegWrtEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RdAddr1 = 5'(i); RdAddr2 = 5'(31 - i);
      #1;
      chk($sformatf("init_rd1_x%0d", i), 64'(RdData1), 64'd0);
      chk($sformatf("init_rd2_x%0d", 31 - i), 64'(RdData2), 64'd0);
    end
    chk("init_cnt", RetireCnt, 64'd0);

    // Same-cycle bypass then array read
    RegWrtEn = 1'b1; RegWrtSrc = 3'd0; MemALUresult = 32'hDEAD_BEEF; RegDst = 5'd5;
    RdAddr1 = 5'd5;
    #1;
    chk("byp_rd1",     64'(RdData1), 64'hDEAD_BEEF);
    chk("byp_wbvalid", 64'(WbValid), 64'd1);
    tick();
    RegWrtEn = 1'b0;
    #1;
    chk("arr_rd1", 64'(RdData1), 64'hDEAD_BEEF);
    chk("arr_cnt", RetireCnt,    64'd1);

    wr_x7("src_pc4",   3'd2, 9'h1FC, 32'h0,         32'h0, 32'h0,         32'h0000_0200);
    wr_x7("src_pcimm", 3'd4, 9'h010, 32'hFFFF_FFF0, 32'h0, 32'h0,         32'h0000_0000);
    wr_x7("src_imm",   3'd3, 9'h0,   32'h1234_5000, 32'h0, 32'h0,         32'h1234_5000);
    wr_x7("src_6",     3'd6, 9'h1FF, 32'hFFFF_FFFF, 32'h1, 32'h2,         32'h0);
    wr_x7("src_mem",   3'd1, 9'h0,   32'h0,         32'h1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    wr_x7("src_5",     3'd5, 9'h0,   32'h0,         32'h1, 32'h2,         32'h0);
    chk("src_cnt", RetireCnt, 64'd7);

    // Write to x0 is dropped but still retires
    RegWrtEn = 1'b1; RegWrtSrc = 3'd0; MemALUresult = 32'hFFFF_FFFF; RegDst = 5'd0;
    RdAddr1 = 5'd0; RdAddr2 = 5'd0;
    #1;
    chk("x0_rd1",     64'(RdData1), 64'd0);
    chk("x0_wbvalid", 64'(WbValid), 64'd0);
    tick();
    RegWrtEn = 1'b0;
    #1;
    chk("x0_rd1_after", 64'(RdData1), 64'd0);
    chk("x0_cnt",       RetireCnt,    64'd8);

    // Reset mid-operation drops the coincident writeback
    RegWrtEn = 1'b1; MemALUresult = 32'hA5A5_A5A5; RegDst = 5'd3;
    tick();
    rst = 1'b1; MemALUresult = 32'h0000_0055; RegDst = 5'd4;
    tick();
    rst = 1'b0; RegWrtEn = 1'b0; RdAddr1 = 5'd3; RdAddr2 = 5'd4;
    #1;
    chk("mid_rst_x3",  64'(RdData1), 64'd0);
    chk("mid_rst_x4",  64'(RdData2), 64'd0);
    chk("mid_rst_cnt", RetireCnt,    64'd0);

    RegWrtEn = 1'b1; MemALUresult = 32'h0000_0077; RegDst = 5'd4;
    tick();
    RegWrtEn = 1'b0;
    #1;
    chk("post_rst_x4",  64'(RdData2), 64'h77);
    chk("post_rst_cnt", RetireCnt,    64'd1);

    // Both ports bypass the same register; then overwrite must not read stale
    RegWrtEn = 1'b1; MemALUresult = 32'h00C0_FFEE; RegDst = 5'd9;
    RdAddr1 = 5'd9; RdAddr2 = 5'd9;
    #1;
    chk("dual_rd1", 64'(RdData1), 64'h00C0_FFEE);
    chk("dual_rd2", 64'(RdData2), 64'h00C0_FFEE);
    tick();
    MemALUresult = 32'h0000_0011;
    #1;
    chk("new_rd1", 64'(RdData1), 64'h11);
    chk("new_rd2", 64'(RdData2), 64'h11);
    tick();
    RegWrtEn = 1'b0;
    #1;
    chk("new_arr", 64'(RdData1), 64'h11);
    chk("fin_cnt", RetireCnt,    64'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
